// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 12
) ();
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wr_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_wr_en, imem_addr, imem_wr_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_wr_en, imem_addr, imem_wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: parses SYNC/LEN/words/CHK frames from a byte stream, writes
// 16-bit words to instruction memory and holds the DSP until a good frame lands.
module imem_loader #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned ADDR_STEP = 2,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 2048,
  parameter logic [7:0]  SYNC      = 8'hA5
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus,
  input  logic         clear,
  output logic         dsp_hold,
  output logic         done,
  output logic         error
);

  localparam int unsigned LEN_W = 12;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        csum_q, csum_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [7:0]        hi_q, hi_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              accept;
  logic [7:0]        sum;
  logic [LEN_W-1:0]  len_full;

  assign accept   = bus.in_valid && in_ready_q;
  assign sum      = csum_q + bus.in_data;
  assign len_full = {len_q[LEN_W-1:8], bus.in_data};

  always_comb begin
    state_d   = state_q;
    csum_d    = csum_q;
    len_d     = len_q;
    idx_d     = idx_q;
    hi_d      = hi_q;
    wr_en_d   = 1'b0;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    done_d    = done_q;
    error_d   = error_q;

    if (clear) done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept && bus.in_data == SYNC) begin
          state_d = S_LEN_HI;
          csum_d  = 8'h00;
          idx_d   = '0;
          hold_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          csum_d  = sum;
          len_d   = {bus.in_data[3:0], 8'h00};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          csum_d = sum;
          len_d  = len_full;
          if (32'(len_full) > MAX_WORDS) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else if (len_full == '0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          csum_d  = sum;
          hi_d    = bus.in_data;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          csum_d    = sum;
          wr_en_d   = 1'b1;
          wr_data_d = {hi_q, bus.in_data};
          addr_d    = ADDR_W'(BASE_ADDR + 32'(idx_q) * ADDR_STEP);
          idx_d     = idx_q + LEN_W'(1);
          state_d   = (idx_q + LEN_W'(1) == len_q) ? S_CHECK : S_DATA_HI;
        end
      end
      S_CHECK: begin
        if (accept) begin
          csum_d = sum;
          if (sum == 8'h00) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end
      S_ERROR: begin
        // clear takes priority; no byte is accepted here since in_ready is low
        if (clear) begin
          state_d = S_IDLE;
          error_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d != S_ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      csum_q     <= 8'h00;
      len_q      <= '0;
      idx_q      <= '0;
      hi_q       <= 8'h00;
      in_ready_q <= 1'b1;
      wr_en_q    <= 1'b0;
      addr_q     <= ADDR_W'(BASE_ADDR);
      wr_data_q  <= 16'h0000;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      csum_q     <= csum_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      hi_q       <= hi_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.imem_wr_en   = wr_en_q;
  assign bus.imem_addr    = addr_q;
  assign bus.imem_wr_data = wr_data_q;
  assign dsp_hold         = hold_q;
  assign done             = done_q;
  assign error            = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad/garbage/zero-length/oversize frames
// and a mid-frame reset, with writes captured by a negedge monitor.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  logic dsp_hold, done, error;

  int vectors = 0;
  int errs    = 0;
  bit gaps    = 1'b0;
  logic [27:0] wq[$];

  imem_loader_if #(.ADDR_W(12)) bus ();

  imem_loader dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .clear    (clear),
    .dsp_hold (dsp_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  // each strobe cycle contains exactly one negedge, so one entry per write cycle
  always @(negedge clk)
    if (bus.imem_wr_en === 1'b1) wq.push_back({bus.imem_addr, bus.imem_wr_data});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_good;
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
    send(8'h40);
  endtask

  task automatic check_good(input string tag);
    @(posedge clk); #1;
    chk({tag, "_nwr"},  32'(wq.size()), 32'd2);
    chk({tag, "_w0"},   32'(wq[0]), 32'({12'h000, 16'h1234}));
    chk({tag, "_w1"},   32'(wq[1]), 32'({12'h002, 16'hABCD}));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_hold"}, 32'(dsp_hold), 32'd0);
    chk({tag, "_err"},  32'(error), 32'd0);
    chk({tag, "_rdy"},  32'(bus.in_ready), 32'd1);
  endtask

  task automatic pulse_clear;
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    @(posedge clk); #1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy",  32'(bus.in_ready), 32'd1);
    chk("rst_wren", 32'(bus.imem_wr_en), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_data", 32'(bus.imem_wr_data), 32'd0);
    chk("rst_hold", 32'(dsp_hold), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err",  32'(error), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Good frame: 00+02+12+34+AB+CD = 0x1C0, so CHK 0x40 brings the sum to 0x00
    send_good();
    check_good("good");

    // Same frame with a bad checksum: writes still happen, then ERROR
    wq.delete();
    send(8'hA5);
    chk("sync_done", 32'(done), 32'd0);
    chk("sync_hold", 32'(dsp_hold), 32'd1);
    send(8'h00); send(8'h02);
    send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
    send(8'h41);
    chk("bad_nwr",  32'(wq.size()), 32'd2);
    chk("bad_w1",   32'(wq[1]), 32'({12'h002, 16'hABCD}));
    chk("bad_err",  32'(error), 32'd1);
    chk("bad_hold", 32'(dsp_hold), 32'd1);
    chk("bad_done", 32'(done), 32'd0);
    chk("bad_rdy",  32'(bus.in_ready), 32'd0);
    // Clear with a simultaneous SYNC: clear wins and the byte is dropped
    pulse_clear();
    chk("clr_err", 32'(error), 32'd0);
    chk("clr_rdy", 32'(bus.in_ready), 32'd1);

    // Leading garbage then the good frame with random valid gaps
    wq.delete();
    gaps = 1'b1;
    send(8'h00); send(8'hFF); send(8'h5A);
    send_good();
    gaps = 1'b0;
    check_good("garb");

    // Zero-length frame
    wq.delete();
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_hold", 32'(dsp_hold), 32'd0);
    chk("zero_nwr",  32'(wq.size()), 32'd0);

    // Oversize length 0x801, then with ignored upper nibble 0xF8
    send(8'hA5); send(8'h08); send(8'h01);
    chk("big_err",  32'(error), 32'd1);
    chk("big_rdy",  32'(bus.in_ready), 32'd0);
    chk("big_done", 32'(done), 32'd0);
    pulse_clear();
    send(8'hA5); send(8'hF8); send(8'h01);
    chk("bigf8_err", 32'(error), 32'd1);
    chk("big_nwr",   32'(wq.size()), 32'd0);
    pulse_clear();
    chk("bigclr_err", 32'(error), 32'd0);

    // Reset after the third data byte of a 2-word frame
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h12); send(8'h34); send(8'hAB);
    reset = 1'b1;
    #1;
    chk("mid_wren", 32'(bus.imem_wr_en), 32'd0);
    chk("mid_data", 32'(bus.imem_wr_data), 32'd0);
    chk("mid_addr", 32'(bus.imem_addr), 32'd0);
    chk("mid_hold", 32'(dsp_hold), 32'd1);
    chk("mid_rdy",  32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_nwr", 32'(wq.size()), 32'd1);
    wq.delete();
    send_good();
    check_good("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
